// File: rtl/keccak_pkg.sv
// Shared Keccak types and sizing constants used by the core and its front-end arbiter.
// Holds the lane width, the arbiter state encoding and the default arbiter sizing.
// Nothing in here is clocked.
package keccak_pkg;

  localparam int w = 64;

  localparam int KECCAK_ARB_NREQ  = 2;
  localparam int KECCAK_ARB_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/keccak_arbiter_if.sv
// Bundle of requester-side and core-side signals of the keccak arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
// Flat per-requester vectors: requester i owns slice i of every field.
interface keccak_arbiter_if
  import keccak_pkg::*;
#(
  parameter int NREQ      = KECCAK_ARB_NREQ,
  parameter int OUT_CNT_W = KECCAK_ARB_CNT_W
);

  logic [NREQ-1:0]           req;
  logic [NREQ*OUT_CNT_W-1:0] out_words;
  logic [NREQ-1:0]           in_valid;
  logic [NREQ-1:0]           in_last;
  logic [NREQ*w-1:0]         in_data;
  logic [NREQ-1:0]           in_ready;
  logic [NREQ-1:0]           out_valid;
  logic [NREQ-1:0]           out_ready;
  logic [w-1:0]              out_data;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           done;
  logic                      kc_valid_n;
  logic                      kc_ready_n;
  logic [w-1:0]              kc_data;
  logic                      kc_ready;
  logic                      kc_valid;
  logic [w-1:0]              kc_dout;

  modport slave (
    input  req, out_words, in_valid, in_last, in_data, out_ready,
    input  kc_ready, kc_valid, kc_dout,
    output in_ready, out_valid, out_data, grant, done,
    output kc_valid_n, kc_ready_n, kc_data
  );

  modport master (
    output req, out_words, in_valid, in_last, in_data, out_ready,
    output kc_ready, kc_valid, kc_dout,
    input  in_ready, out_valid, out_data, grant, done,
    input  kc_valid_n, kc_ready_n, kc_data
  );

endinterface

// File: rtl/keccak_arbiter_rr_picker.sv
// Round-robin selector: first set req strictly after last_owner, wrapping.
// Purely combinational, zero latency.
// No handshake; result is meaningful only when some req bit is set.
module rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [NREQ-1:0]  owner,
  output logic [IDX_W-1:0] owner_idx
);

  int idx;

  // Scan from farthest to nearest so the nearest requester after last_owner overwrites.
  always_comb begin
    owner     = '0;
    owner_idx = '0;
    idx       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_owner) + k) % NREQ;
      if (req[idx]) begin
        owner      = '0;
        owner[idx] = 1'b1;
        owner_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core among NREQ requesters, one whole transaction at a time.
// Grant 1 cycle after req; data paths are combinational pass-through (0 cycles).
// Owner stalls: kc_ready stalls in_ready, out_ready stalls kc_ready_n; non-owners see nothing.
module keccak_arbiter
  import keccak_pkg::*;
#(
  parameter int NREQ      = KECCAK_ARB_NREQ,
  parameter int OUT_CNT_W = KECCAK_ARB_CNT_W
) (
  input logic             clk,
  input logic             rst,
  keccak_arbiter_if.slave bus
);

  localparam int IDX_W = (NREQ > 2) ? 2 : 1;

  arb_state_t           state;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     last_owner;
  logic [NREQ-1:0]      grant_q;
  logic [NREQ-1:0]      done_q;
  logic [OUT_CNT_W-1:0] cnt;
  logic [NREQ-1:0]      pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 in_xfer;
  logic                 out_xfer;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (bus.req),
    .last_owner (last_owner),
    .owner      (pick),
    .owner_idx  (pick_idx)
  );

  assign in_xfer  = (state == LOAD) && bus.in_valid[owner] && bus.kc_ready;
  assign out_xfer = (state == DUMP) && bus.kc_valid && bus.out_ready[owner];

  assign bus.grant = grant_q;
  assign bus.done  = done_q;

  // Transaction sequencer: grant, stream in, count words out, release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NREQ - 1);
      grant_q    <= '0;
      done_q     <= '0;
      cnt        <= '0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            owner   <= pick_idx;
            grant_q <= pick;
            cnt     <= bus.out_words[int'(pick_idx)*OUT_CNT_W +: OUT_CNT_W];
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (in_xfer && bus.in_last[owner]) begin
            if (cnt != '0) begin
              state <= DUMP;
            end else begin
              state   <= RELEASE;
              done_q  <= grant_q;
              grant_q <= '0;
            end
          end
        end
        DUMP: begin
          if (out_xfer && (cnt != '0)) begin
            cnt <= cnt - OUT_CNT_W'(1);
            if (cnt == OUT_CNT_W'(1)) begin
              state   <= RELEASE;
              done_q  <= grant_q;
              grant_q <= '0;
            end
          end
        end
        RELEASE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Steer the owner's streams to and from the core; everything idle-valued otherwise.
  always_comb begin
    bus.in_ready   = '0;
    bus.out_valid  = '0;
    bus.out_data   = '0;
    bus.kc_data    = '0;
    bus.kc_valid_n = 1'b1;
    bus.kc_ready_n = 1'b1;
    case (state)
      LOAD: begin
        bus.kc_data    = bus.in_data[int'(owner)*w +: w];
        bus.kc_valid_n = !bus.in_valid[owner];
        bus.in_ready   = grant_q & {NREQ{bus.kc_ready}};
      end
      DUMP: begin
        bus.out_valid  = grant_q & {NREQ{bus.kc_valid}};
        bus.out_data   = bus.kc_dout;
        bus.kc_ready_n = !bus.out_ready[owner];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Self-checking bench for keccak_arbiter with a behavioural core model and scoreboards.
// Inputs change 1 time unit after posedge, outputs are sampled on negedge.
// The core model emits out_words words once the owner's last input word is taken.
module tb_keccak_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  keccak_arbiter_if #(.NREQ(2), .OUT_CNT_W(16)) bus ();

  keccak_arbiter #(.NREQ(2), .OUT_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] in_word(int r, int k);
    return {8'hA0 + 8'(r), 24'h000000, 32'(k) + 32'h100};
  endfunction

  function automatic logic [63:0] out_word(int r, int k);
    return {8'hC0 + 8'(r), 24'hDEC0DE, 32'(k * 7 + 3)};
  endfunction

  task automatic clear_inputs();
    bus.req       = '0;
    bus.out_words = '0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    bus.kc_ready  = 1'b0;
    bus.kc_valid  = 1'b0;
    bus.kc_dout   = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction for requester r; scoreboards both streams and reports timing observations.
  task automatic drive_txn(input logic [1:0] mask, input int r, input int nin, input int nout,
                           input int os_at, input int os_len, input int ks_len, input bit noise,
                           output int g, output int gap, output int rdy_low, output int err);
    logic [63:0] exp_in[$];
    logic [63:0] exp_out[$];
    logic [63:0] e;
    int cyc, win, pushed, pend, oidx, os_cnt, last_x, done_c, o;
    o = 1 - r;
    cyc = 0; win = 0; pushed = 0; pend = 0; oidx = 0; os_cnt = 0;
    last_x = -100; done_c = -1;
    gap = -1; rdy_low = 0; err = 0;
    for (int k = 0; k < nout; k++) exp_out.push_back(out_word(r, k));
    bus.out_words = '0;
    bus.out_words[r*16 +: 16] = 16'(nout);
    bus.req = mask;
    @(posedge clk);
    #1;
    bus.req = '0;
    g = int'(bus.grant);
    while (done_c < 0 && cyc < 300) begin
      bus.in_valid  = '0;
      bus.in_last   = '0;
      bus.in_data   = '0;
      bus.out_ready = '0;
      if (noise) begin
        bus.in_valid[o]  = 1'b1;
        bus.out_ready[o] = 1'b1;
      end
      if (win < nin) begin
        if (pushed == win) begin
          exp_in.push_back(in_word(r, win));
          pushed++;
        end
        bus.in_valid[r]         = 1'b1;
        bus.in_data[r*64 +: 64] = in_word(r, win);
        bus.in_last[r]          = (win == nin - 1);
      end
      bus.kc_ready = (cyc >= ks_len);
      bus.kc_valid = (pend > 0);
      bus.kc_dout  = (pend > 0) ? out_word(r, oidx) : '0;
      if (pend > 0) begin
        if (oidx == os_at && os_cnt < os_len) begin
          os_cnt++;
          bus.out_ready[r] = 1'b0;
        end else begin
          bus.out_ready[r] = 1'b1;
        end
      end
      @(negedge clk);
      if (bus.in_ready[o] !== 1'b0 || bus.out_valid[o] !== 1'b0) err++;
      if (bus.kc_ready_n === 1'b0) rdy_low++;
      if (bus.kc_ready === 1'b0 && bus.in_ready[r] !== 1'b0) err++;
      if (pend > 0 && bus.out_ready[r] === 1'b0 && bus.kc_ready_n !== 1'b1) err++;
      if (bus.done[r] === 1'b1) done_c = cyc;
      if (bus.kc_valid_n === 1'b0 && bus.kc_ready === 1'b1) begin
        total++;
        if (exp_in.size() == 0) begin
          bad++;
          $display("FAIL kc_extra_in r%0d: got %h want no transfer", r, bus.kc_data);
        end else begin
          e = exp_in.pop_front();
          if (bus.kc_data !== e) begin
            bad++;
            $display("FAIL kc_data r%0d word%0d: got %h want %h", r, win, bus.kc_data, e);
          end
        end
        if (win < nin && bus.in_last[r] === 1'b1) begin
          pend   = nout;
          last_x = cyc;
        end
        win++;
      end
      if (bus.out_valid[r] === 1'b1 && bus.out_ready[r] === 1'b1) begin
        total++;
        if (exp_out.size() == 0) begin
          bad++;
          $display("FAIL out_extra r%0d: got %h want no word", r, bus.out_data);
        end else begin
          e = exp_out.pop_front();
          if (bus.out_data !== e) begin
            bad++;
            $display("FAIL out_data r%0d word%0d: got %h want %h", r, oidx, bus.out_data, e);
          end
        end
        oidx++;
        pend--;
        last_x = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (done_c < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout r%0d: got no done in %0d cycles want done", r, cyc);
    end else begin
      gap = done_c - last_x;
    end
    clear_inputs();
    @(negedge clk);
    total++;
    if (bus.done !== 2'b00 || bus.grant !== 2'b00) begin
      bad++;
      $display("FAIL post_release r%0d: got done=%b grant=%b want 00 00", r, bus.done, bus.grant);
    end
    @(posedge clk);
    #1;
    total++;
    if (win != nin || exp_out.size() != 0) begin
      bad++;
      $display("FAIL word_count r%0d: got in=%0d out_left=%0d want in=%0d out_left=0",
               r, win, exp_out.size(), nin);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    total++;
    if (bus.grant !== 2'b00 || bus.done !== 2'b00) begin
      bad++;
      $display("FAIL reset_grant_done: got %b %b want 00 00", bus.grant, bus.done);
    end
    total++;
    if (bus.in_ready !== 2'b00 || bus.out_valid !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready_valid: got %b %b want 00 00", bus.in_ready, bus.out_valid);
    end
    total++;
    if (bus.kc_valid_n !== 1'b1 || bus.kc_ready_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_core_ctl: got %b %b want 1 1", bus.kc_valid_n, bus.kc_ready_n);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int g, gap, rl, err;
    drive_txn(2'b01, 0, 3, 2, 99, 0, 0, 1'b0, g, gap, rl, err);
    total++;
    if (g != 1) begin bad++; $display("FAIL basic_grant: got %0d want 1", g); end
    total++;
    if (gap != 1) begin bad++; $display("FAIL basic_done_gap: got %0d want 1", gap); end
    total++;
    if (rl != 2) begin bad++; $display("FAIL basic_ready_cycles: got %0d want 2", rl); end
    total++;
    if (err != 0) begin bad++; $display("FAIL basic_protocol: got %0d errors want 0", err); end
  endtask

  task automatic test_round_robin();
    int g, gap, rl, err;
    int exp_owner[3] = '{0, 1, 0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_txn(2'b11, exp_owner[i], 1, 1, 99, 0, 0, 1'b0, g, gap, rl, err);
      total++;
      if (g != (1 << exp_owner[i])) begin
        bad++;
        $display("FAIL rr_grant_%0d: got %0d want %0d", i, g, 1 << exp_owner[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g, gap, rl, err;
    drive_txn(2'b10, 1, 2, 6, 2, 4, 2, 1'b0, g, gap, rl, err);
    total++;
    if (g != 2) begin bad++; $display("FAIL bp_grant: got %0d want 2", g); end
    total++;
    if (rl != 6) begin bad++; $display("FAIL bp_ready_cycles: got %0d want 6", rl); end
    total++;
    if (err != 0) begin bad++; $display("FAIL bp_protocol: got %0d errors want 0", err); end
    total++;
    if (gap != 1) begin bad++; $display("FAIL bp_done_gap: got %0d want 1", gap); end
  endtask

  task automatic test_zero_out();
    int g, gap, rl, err;
    drive_txn(2'b01, 0, 2, 0, 99, 0, 0, 1'b0, g, gap, rl, err);
    total++;
    if (gap != 1) begin bad++; $display("FAIL zero_done_gap: got %0d want 1", gap); end
    total++;
    if (rl != 0) begin bad++; $display("FAIL zero_no_dump: got %0d ready cycles want 0", rl); end
  endtask

  task automatic test_isolation();
    int g, gap, rl, err;
    drive_txn(2'b10, 1, 3, 3, 99, 0, 0, 1'b1, g, gap, rl, err);
    total++;
    if (err != 0) begin bad++; $display("FAIL iso_protocol: got %0d errors want 0", err); end
    total++;
    if (rl != 3) begin bad++; $display("FAIL iso_ready_cycles: got %0d want 3", rl); end
  endtask

  task automatic test_reset_mid();
    int g, gap, rl, err;
    apply_reset();
    bus.out_words[15:0] = 16'd4;
    bus.req = 2'b01;
    @(posedge clk);
    #1;
    bus.req            = '0;
    bus.in_valid[0]    = 1'b1;
    bus.in_last[0]     = 1'b1;
    bus.in_data[63:0]  = in_word(0, 0);
    bus.kc_ready       = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.kc_valid  = 1'b1;
    bus.kc_dout   = out_word(0, 0);
    bus.out_ready = 2'b01;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 2'b01) begin
      bad++;
      $display("FAIL rstmid_in_dump: got out_valid=%b want 01", bus.out_valid);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if (bus.grant !== 2'b00 || bus.out_valid !== 2'b00 || bus.kc_ready_n !== 1'b1 || bus.done !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_outputs: got grant=%b out_valid=%b kc_ready_n=%b done=%b want 00 00 1 00",
               bus.grant, bus.out_valid, bus.kc_ready_n, bus.done);
    end
    clear_inputs();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    drive_txn(2'b10, 1, 2, 1, 99, 0, 0, 1'b0, g, gap, rl, err);
    total++;
    if (g != 2) begin bad++; $display("FAIL rstmid_regrant: got %0d want 2", g); end
    total++;
    if (gap != 1) begin bad++; $display("FAIL rstmid_done_gap: got %0d want 1", gap); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_zero_out();
    test_isolation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
